axil_rr_master: RTL and testbench
=================================

# axil_rr_master

Round-robin AXI4-Lite master arbiter that shares one AXI4-Lite slave port (the register-file slave) among NUM_REQ simple requesters. Each requester presents a single-beat read or write on a valid/ready request port; the block grants one requester at a time and runs the full AXI-Lite transaction on the master side. It returns the response to the granted requester only. One transaction is outstanding at a time.

## Interface
- NUM_REQ, 2: number of requesters, ≥2.
- M_AXI_ADDR_WIDTH, 32: byte-address width.
- M_AXI_DATA_WIDTH, 32: data width, multiple of 8.
- TIMEOUT_CYCLES, 255: response watchdog limit; used only with AXIL_RR_TIMEOUT_EN.

Ports:
- m_axi_clk  in  1  sole clock, all logic on rising edge.
- m_axi_reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*AW  requester k at [k*AW +: AW].
- req_wdata  in  NUM_REQ*DW  requester k at [k*DW +: DW].
- req_wstrb  in  NUM_REQ*DW/8  requester k at [k*DW/8 +: DW/8].
- req_ready  out  NUM_REQ  one-hot grant; request accepted on req_valid[k]&req_ready[k].
- rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse to the granted requester.
- rsp_rdata  out  DW  read data, valid with rsp_valid; 0 for writes.
- rsp_resp  out  2  AXI response code, valid with rsp_valid.
- m_axi_awvalid/awaddr/awready, m_axi_wvalid/wdata/wstrb/wready, m_axi_bvalid/bresp/bready, m_axi_arvalid/araddr/arready, m_axi_rvalid/rdata/rresp/rready: standard AXI4-Lite master side, widths per parameters.

## Operation
- States: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: req_ready is combinational. It is the one-hot of the first set req_valid bit, searching from (ptr+1) mod NUM_REQ upward with wrap. On a grant edge the block latches the grant index, write flag, address, wdata and wstrb, and sets ptr to the grant index. Next state is WR or RD_ADDR.
- Outside IDLE, req_ready is 0.
- WR: awvalid and wvalid are both asserted. Each one drops independently on its own handshake. When both have completed (including the same cycle), go to WR_RESP.
- WR_RESP: bready=1. On the B handshake, latch bresp and go to DONE.
- RD_ADDR: arvalid=1 until the AR handshake, then RD_DATA.
- RD_DATA: rready=1. On the R handshake, latch rdata and rresp and go to DONE.
- DONE: rsp_valid[grant]=1 for exactly one cycle, then IDLE.
- rsp_rdata/rsp_resp hold their values until the next DONE.
- AXI address and data outputs are driven from the latched registers and stay stable while valid is high.
- Requesters may drop or change req_* after their grant without affecting the transaction in flight.
- Reset values:
  - all valid, ready and rsp_valid outputs 0;
  - rsp_rdata 0, rsp_resp 0;
  - AXI addr/data/strb 0;
  - state IDLE;
  - ptr NUM_REQ-1, so requester 0 wins the first contention.
- Reset mid-transaction: all master valids and readies are 0 from the next cycle. The transaction is abandoned and no rsp_valid is issued. The system resets the slave together with this block.

## Timing
- Grant edge to awvalid/wvalid/arvalid high: 1 cycle.
- Minimum write with zero-wait slave: grant, WR 1 cycle, WR_RESP 1 cycle, DONE. rsp_valid is asserted 3 cycles after the grant edge.
- Read minimum is the same: rsp_valid 3 cycles after the grant edge.
- Back-to-back: the next grant is possible in the IDLE cycle after DONE. Minimum request-to-request period is 4 cycles.
- Against a slave that raises wready only after the AW handshake, WR lasts at least 2 cycles.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0.

## Configuration
- AXIL_RR_TIMEOUT_EN defined:
  - A cycle counter is cleared on the grant edge and increments in WR, WR_RESP, RD_ADDR and RD_DATA.
  - If it reaches TIMEOUT_CYCLES before the awaited handshake, all master valids and readies drop the next cycle.
  - The state goes to DONE with rsp_resp=2'b11 (DECERR) and rsp_rdata=0.
  - A late slave handshake after abort is ignored.
- AXIL_RR_TIMEOUT_EN undefined: no counter; the block waits indefinitely and TIMEOUT_CYCLES is unused.

## Test plan
- Req0 writes 0xDEADBEEF to addr 0x04 with wstrb 0xF, then reads 0x04 → write rsp_resp 2'b00; read rsp_rdata 0xDEADBEEF, rsp_resp 2'b00; rsp_valid[0] each time, rsp_valid[1] never.
- Req0 and req1 valid in the same cycle after reset, then held → grant order 0,1,0,1; each grant's rsp_valid on the matching bit only.
- Req1 writes with wstrb 0x3 of 0x12345678 over 0xAAAAAAAA at addr 0x08, then reads → 0xAAAA5678.
- Req0 reads addr 0x40 (beyond slave depth 8) → rsp_resp 2'b10, rsp_rdata 0; the next request completes normally.
- Assert m_axi_reset while in WR_RESP with bvalid held low → all master outputs 0 next cycle, no rsp_valid, next grant goes to req0.
- With AXIL_RR_TIMEOUT_EN and TIMEOUT_CYCLES=16, a slave that never asserts arready → arvalid drops, rsp_resp 2'b11 exactly 17 cycles after the grant edge.

Source files
------------

// File: rtl/axil_rr_master.sv
// axil_rr_master: round-robin share of one AXI4-Lite master port among
// NUM_REQ single-beat requesters, one transaction outstanding at a time.
//
// Ports:
//   m_axi_clk, m_axi_reset  clock, synchronous active-high reset
//   req_valid/req_write     per-requester request and direction
//   req_addr/wdata/wstrb    per-requester fields, packed k-major
//   req_ready               one-hot grant (IDLE only)
//   rsp_valid               one-hot completion pulse to the granted requester
//   rsp_rdata/rsp_resp      response data/code, held until the next completion
//   m_axi_*                 AXI4-Lite master (AW, W, B, AR, R)
// Optional: define AXIL_RR_TIMEOUT_EN for a response watchdog that aborts
// with DECERR after TIMEOUT_CYCLES busy cycles.

module axil_rr_master #(
  parameter int NUM_REQ          = 2,
  parameter int M_AXI_ADDR_WIDTH = 32,
  parameter int M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic m_axi_clk,
  input  logic m_axi_reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_write,
  input  logic [NUM_REQ*M_AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*M_AXI_DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*(M_AXI_DATA_WIDTH/8)-1:0] req_wstrb,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [M_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0] rsp_resp,
  output logic m_axi_awvalid,
  output logic [M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  input  logic m_axi_awready,
  output logic m_axi_wvalid,
  output logic [M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic m_axi_wready,
  input  logic m_axi_bvalid,
  input  logic [1:0] m_axi_bresp,
  output logic m_axi_bready,
  output logic m_axi_arvalid,
  output logic [M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  input  logic m_axi_arready,
  input  logic m_axi_rvalid,
  input  logic [M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0] m_axi_rresp,
  output logic m_axi_rready
);

  localparam int AW = M_AXI_ADDR_WIDTH;
  localparam int DW = M_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP,
    S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0] ptr_q, gnt_q, gnt_c;
  logic          gnt_any, grant;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic          aw_done_q, w_done_q;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic          timeout, abort;
  int            j;

  // Search starts just past the last winner and wraps; walking the
  // offsets downward lets the nearest valid requester win.
  always_comb begin
    gnt_c   = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = (int'(ptr_q) + i) % NUM_REQ;
      if (req_valid[j]) begin
        gnt_c   = IW'(j);
        gnt_any = 1'b1;
      end
    end
  end

  assign grant = (state_q == S_IDLE) & gnt_any & ~m_axi_reset;
  assign req_ready = grant ? (NUM_REQ'(1) << gnt_c) : '0;
  assign rsp_valid = (state_q == S_DONE) ? (NUM_REQ'(1) << gnt_q) : '0;

  assign m_axi_awvalid = (state_q == S_WR) & ~aw_done_q;
  assign m_axi_wvalid  = (state_q == S_WR) & ~w_done_q;
  assign m_axi_bready  = (state_q == S_WR_RESP);
  assign m_axi_arvalid = (state_q == S_RD_ADDR);
  assign m_axi_rready  = (state_q == S_RD_DATA);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;
  assign b_hs  = m_axi_bvalid & m_axi_bready;
  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs  = m_axi_rvalid & m_axi_rready;

`ifdef AXIL_RR_TIMEOUT_EN
  logic [31:0] cnt_q;
  logic        busy;

  assign busy = (state_q != S_IDLE) & (state_q != S_DONE);
  assign timeout = busy & (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge m_axi_clk) begin
    if (m_axi_reset) cnt_q <= '0;
    else if (grant)  cnt_q <= '0;
    else if (busy)   cnt_q <= cnt_q + 32'd1;
  end
`else
  // No watchdog: this is constant false.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Entering DONE without a B or R handshake can only be a watchdog abort.
  assign abort = (state_d == S_DONE) & ~b_hs & ~r_hs;

  always_ff @(posedge m_axi_clk) begin
    if (m_axi_reset) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (grant)
          state_d = req_write[gnt_c] ? S_WR : S_RD_ADDR;
      S_WR:
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs))
          state_d = S_WR_RESP;
        else if (timeout)
          state_d = S_DONE;
      S_WR_RESP:
        if (b_hs | timeout) state_d = S_DONE;
      S_RD_ADDR:
        if (ar_hs)        state_d = S_RD_DATA;
        else if (timeout) state_d = S_DONE;
      S_RD_DATA:
        if (r_hs | timeout) state_d = S_DONE;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_clk) begin
    if (m_axi_reset) begin
      ptr_q     <= IW'(NUM_REQ - 1);
      gnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      if (grant) begin
        ptr_q     <= gnt_c;
        gnt_q     <= gnt_c;
        addr_q    <= req_addr[int'(gnt_c)*AW +: AW];
        wdata_q   <= req_wdata[int'(gnt_c)*DW +: DW];
        wstrb_q   <= req_wstrb[int'(gnt_c)*SW +: SW];
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (b_hs) begin
        rsp_rdata <= '0;
        rsp_resp  <= m_axi_bresp;
      end
      if (r_hs) begin
        rsp_rdata <= m_axi_rdata;
        rsp_resp  <= m_axi_rresp;
      end
      if (abort) begin
        rsp_rdata <= '0;
        rsp_resp  <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_axil_rr_master.sv
// tb_axil_rr_master: directed bench for axil_rr_master against a small
// 8-word AXI4-Lite register-file slave model.

module tb_axil_rr_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  logic hold_b, no_arready;
  int   n_chk, n_fail;

  always #5 clk = ~clk;

  axil_rr_master #(
    .NUM_REQ(2), .M_AXI_ADDR_WIDTH(32),
    .M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .m_axi_clk(clk), .m_axi_reset(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .m_axi_awvalid(awvalid), .m_axi_awaddr(awaddr),
    .m_axi_awready(awready),
    .m_axi_wvalid(wvalid), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb), .m_axi_wready(wready),
    .m_axi_bvalid(bvalid), .m_axi_bresp(bresp),
    .m_axi_bready(bready),
    .m_axi_arvalid(arvalid), .m_axi_araddr(araddr),
    .m_axi_arready(arready),
    .m_axi_rvalid(rvalid), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rready(rready)
  );

  // Slave: 8 words at 0x00-0x1C, SLVERR beyond.
  logic [31:0] mem [8];
  logic        aw_got, w_got;
  logic [31:0] aw_a, w_d;
  logic [3:0]  w_s;
  logic        a_ok, d_ok;
  logic [31:0] wa, wd;
  logic [3:0]  ws;

  assign awready = 1'b1;
  assign wready  = 1'b1;
  assign arready = ~no_arready;
  assign a_ok = aw_got | (awvalid & awready);
  assign d_ok = w_got | (wvalid & wready);
  assign wa = aw_got ? aw_a : awaddr;
  assign wd = w_got ? w_d : wdata;
  assign ws = w_got ? w_s : wstrb;

  initial for (int i = 0; i < 8; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      bvalid <= 1'b0; rvalid <= 1'b0;
      aw_got <= 1'b0; w_got <= 1'b0;
      bresp <= '0; rresp <= '0; rdata <= '0;
    end else begin
      if (bvalid & bready) bvalid <= 1'b0;
      if (rvalid & rready) rvalid <= 1'b0;
      if (awvalid & awready) begin
        aw_got <= 1'b1; aw_a <= awaddr;
      end
      if (wvalid & wready) begin
        w_got <= 1'b1; w_d <= wdata; w_s <= wstrb;
      end
      if (a_ok & d_ok & ~bvalid & ~hold_b) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        bvalid <= 1'b1;
        bresp  <= (wa < 32'h20) ? 2'b00 : 2'b10;
        if (wa < 32'h20)
          for (int b = 0; b < 4; b++)
            if (ws[b]) mem[wa[4:2]][8*b +: 8] <= wd[8*b +: 8];
      end
      if (arvalid & arready) begin
        rvalid <= 1'b1;
        rresp  <= (araddr < 32'h20) ? 2'b00 : 2'b10;
        rdata  <= (araddr < 32'h20) ? mem[araddr[4:2]] : '0;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction from requester k; inputs are scrambled right after
  // the grant edge. lat counts negedges from grant edge to rsp_valid.
  task automatic do_req(input int k, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s,
                        output logic [31:0] rd,
                        output logic [1:0] rp,
                        output int lat,
                        output logic [1:0] rv);
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k*32 +: 32] = a;
    req_wdata[k*32 +: 32] = d;
    req_wstrb[k*4 +: 4] = s;
    #1;
    check("grant", req_ready, 64'(2'b01 << k));
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_write[k] = ~wr;
    req_addr[k*32 +: 32] = 32'hFFFF_FFFC;
    req_wdata[k*32 +: 32] = 32'h0BAD_0BAD;
    req_wstrb[k*4 +: 4] = 4'h0;
    lat = 0; rv = '0; rd = 'x; rp = 'x;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (rsp_valid != 0) begin
        lat = n; rv = rsp_valid;
        rd = rsp_rdata; rp = rsp_resp;
        break;
      end
    end
  endtask

  logic [31:0] rd;
  logic [1:0]  rp, rv, seen;
  int          lat;
  int          g [4];
  int          gt [4];
  int          ng, nr;
  logic        drop;

  initial begin
    n_chk = 0; n_fail = 0;
    hold_b = 1'b0; no_arready = 1'b0;
    req_valid = '0; req_write = '0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mvalid",
          {awvalid, wvalid, bready, arvalid, rready}, 0);
    check("rst_ready", {req_ready, rsp_valid}, 0);
    check("rst_rsp", {rsp_rdata, rsp_resp}, 0);
    check("rst_axi", {awaddr, wdata, wstrb, araddr}, 0);
    rst = 1'b0;

    // Contention from reset, both held: 0,1,0,1.
    @(negedge clk);
    req_valid = 2'b11;
    req_addr = {32'h04, 32'h04};
    ng = 0; nr = 0; drop = 1'b0;
    for (int c = 0; c < 80 && nr < 4; c++) begin
      if (c != 0) @(negedge clk);
      if (drop) req_valid = 2'b00;
      #1;
      if (rsp_valid != 0) begin
        check($sformatf("rr_rsp%0d", nr), rsp_valid,
              64'(2'b01 << g[nr]));
        nr++;
      end
      if (req_ready != 0 && ng < 4) begin
        g[ng] = req_ready[1] ? 1 : 0;
        gt[ng] = c;
        ng++;
        if (ng == 4) drop = 1'b1;
      end
    end
    req_valid = 2'b00;
    check("rr_count", 64'(nr), 4);
    check("rr_order", {g[0][3:0], g[1][3:0], g[2][3:0], g[3][3:0]},
          64'h0101);
    check("rr_period", 64'(gt[1] - gt[0]), 4);

    // Req0 write then read back.
    do_req(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, rd, rp, lat, rv);
    check("w0_lat", 64'(lat), 3);
    check("w0_rv", rv, 2'b01);
    check("w0_resp", rp, 2'b00);
    do_req(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, rp, lat, rv);
    check("r0_lat", 64'(lat), 3);
    check("r0_rv", rv, 2'b01);
    check("r0_data", rd, 32'hDEADBEEF);
    check("r0_resp", rp, 2'b00);

    // Req1 partial-strobe write.
    do_req(1, 1'b1, 32'h08, 32'hAAAAAAAA, 4'hF, rd, rp, lat, rv);
    check("w1a_rv", rv, 2'b10);
    check("w1a_data", rd, 0);
    do_req(1, 1'b1, 32'h08, 32'h12345678, 4'h3, rd, rp, lat, rv);
    check("w1b_resp", rp, 2'b00);
    do_req(1, 1'b0, 32'h08, 32'h0, 4'h0, rd, rp, lat, rv);
    check("r1_rv", rv, 2'b10);
    check("r1_data", rd, 32'hAAAA5678);

    // Out-of-range read, then a normal one; response holds after DONE.
    do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, rp, lat, rv);
    check("oob_resp", rp, 2'b10);
    check("oob_data", rd, 0);
    do_req(1, 1'b0, 32'h04, 32'h0, 4'h0, rd, rp, lat, rv);
    check("after_oob", {rp, rd}, {2'b00, 32'hDEADBEEF});
    repeat (3) @(negedge clk);
    check("rsp_hold", {rsp_resp, rsp_rdata},
          {2'b00, 32'hDEADBEEF});

    // Reset while waiting for B.
    hold_b = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[31:0] = 32'h0C; req_wstrb[3:0] = 4'hF;
    @(posedge clk);
    #1 req_valid = 2'b00;
    for (int n = 0; n < 20 && !bready; n++) @(negedge clk);
    check("in_wr_resp", bready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out",
          {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    rst = 1'b0;
    hold_b = 1'b0;
    seen = '0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("mid_rst_norsp", seen, 0);
    req_valid = 2'b11;
    #1;
    check("rst_ptr", req_ready, 2'b01);
    req_valid = 2'b00;

`ifdef AXIL_RR_TIMEOUT_EN
    no_arready = 1'b1;
    do_req(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, rp, lat, rv);
    check("to_lat", 64'(lat), 17);
    check("to_resp", {rp, rd}, {2'b11, 32'h0});
    check("to_arvalid", arvalid, 1'b0);
    no_arready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
